// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - N-to-1 round-robin valid/ready arbiter with a registered output slot
module rr_stream_arbiter #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic [N-1:0]         valid_up_in,
    output logic [N-1:0]         ready_up_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_down_out,
    input  logic                 ready_down_in,
    output logic [IDW-1:0]       grant_id_out
);

    // Output slot and rotating priority pointer
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_ptr;

    logic             w_can_load;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [WIDTH-1:0] w_win_data;
    logic             w_up_xfer;
    logic             w_down_xfer;

    // Index reached by stepping 'step' places past 'base', wrapping at N.
    // Works for any N, not only powers of two.
    function automatic logic [IDW-1:0] f_wrap_idx(input logic [IDW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= N) begin
            s = s - N;
        end
        return s[IDW-1:0];
    endfunction

    // The slot can accept a word when empty or when it drains this cycle
    always_comb begin
        w_can_load = !r_valid || ready_down_in;
    end

    // Scan from the farthest offset back to ptr+1 so the nearest valid requester wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = N; k >= 1; k--) begin
            if (valid_up_in[f_wrap_idx(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = f_wrap_idx(r_ptr, k);
            end
        end
    end

    // Select the winning lane's data word
    always_comb begin
        w_win_data = data_in[int'(w_winner)*WIDTH +: WIDTH];
    end

    // Ready goes only to the winner; held low while reset is asserted
    always_comb begin
        ready_up_out = '0;
        if (w_found && !rst) begin
            ready_up_out[w_winner] = w_can_load;
        end
    end

    // Transfer strobes; winner existence already implies its valid is high
    always_comb begin
        w_up_xfer   = w_found && w_can_load;
        w_down_xfer = r_valid && ready_down_in;
    end

    // Slot load/drain and pointer update; ptr moves only on an accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_ptr   <= IDW'(N - 1);
        end else begin
            if (w_up_xfer) begin
                r_data  <= w_win_data;
                r_valid <= 1'b1;
                r_grant <= w_winner;
                r_ptr   <= w_winner;
            end else if (w_down_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data;
    assign valid_down_out = r_valid;
    assign grant_id_out   = r_grant;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - scoreboard bench for rr_stream_arbiter
module tb_rr_stream_arbiter;

    localparam int WIDTH = 32;
    localparam int N = 4;
    localparam int IDW = 2;

    logic                 clk;
    logic                 rst;
    logic [N*WIDTH-1:0]   data_in;
    logic [N-1:0]         valid_up_in;
    logic [N-1:0]         ready_up_out;
    logic [WIDTH-1:0]     data_out;
    logic                 valid_down_out;
    logic                 ready_down_in;
    logic [IDW-1:0]       grant_id_out;

    logic [WIDTH-1:0] lane [N];

    int n_vec;
    int n_err;

    // reference model state
    logic        m_valid;
    int          m_ptr;
    int          last_xfer;
    int          exp_id_q[$];
    logic [31:0] exp_data_q[$];
    int          obs_ids[$];

    rr_stream_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .valid_up_in    (valid_up_in),
        .ready_up_out   (ready_up_out),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in),
        .grant_id_out   (grant_id_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_in[i*WIDTH +: WIDTH] = lane[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: compare at negedge against the model, then advance to posedge+1
    task automatic step();
        logic        found;
        int          win;
        logic        can_load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        last_xfer = -1;
        if (rst) begin
            chk("rst_ready", 32'(ready_up_out), 32'h0);
            chk("rst_valid", 32'(valid_down_out), 32'h0);
            chk("rst_data", data_out, 32'h0);
            m_valid = 1'b0;
            m_ptr = N - 1;
            exp_id_q.delete();
            exp_data_q.delete();
        end else begin
            found = 1'b0;
            win = 0;
            for (int k = N; k >= 1; k--) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (valid_up_in[idx]) begin
                    found = 1'b1;
                    win = idx;
                end
            end
            can_load = !m_valid || ready_down_in;
            exp_rdy = '0;
            if (found && can_load) exp_rdy[win] = 1'b1;
            chk("ready_up", 32'(ready_up_out), 32'(exp_rdy));
            chk("valid_down", 32'(valid_down_out), 32'(m_valid));
            if (m_valid && ready_down_in) begin
                chk("sb_has_entry", 32'(exp_id_q.size() > 0), 32'h1);
                if (exp_id_q.size() > 0) begin
                    chk("out_data", data_out, exp_data_q.pop_front());
                    chk("out_id", 32'(grant_id_out), 32'(exp_id_q.pop_front()));
                    obs_ids.push_back(int'(grant_id_out));
                end
            end
            if (found && can_load) begin
                exp_id_q.push_back(win);
                exp_data_q.push_back(lane[win]);
                m_ptr = win;
                m_valid = 1'b1;
                last_xfer = win;
            end else if (m_valid && ready_down_in) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        obs_ids.delete();
    endtask

    initial begin
        int since_l2;
        int l1_sent;
        int l1_seen;
        n_vec = 0;
        n_err = 0;
        m_valid = 1'b0;
        m_ptr = N - 1;
        last_xfer = -1;
        for (int i = 0; i < N; i++) lane[i] = 32'h100 + 32'(i);
        valid_up_in = 4'b1111;
        ready_down_in = 1'b1;
        rst = 1'b1;
        #1;

        // 1: reset with all lanes requesting, first grant goes to lane 0
        do_reset(10);
        valid_up_in = 4'b0000;
        valid_up_in = 4'b1111;
        step();
        valid_up_in = 4'b0000;
        step();
        chk("first_grant_id", 32'(obs_ids.size() > 0 ? obs_ids[0] : -1), 32'h0);

        // 2: single requester on lane 2
        do_reset(2);
        lane[2] = 32'hA5A5_0002;
        valid_up_in = 4'b0100;
        #1;
        chk("single_ready", 32'(ready_up_out), 32'h4);
        step();
        valid_up_in = 4'b0000;
        chk("single_data", data_out, 32'hA5A5_0002);
        chk("single_id", 32'(grant_id_out), 32'h2);
        chk("single_valid", 32'(valid_down_out), 32'h1);
        step();

        // 3: all lanes valid, full-rate rotation
        do_reset(2);
        for (int i = 0; i < N; i++) lane[i] = 32'h100 + 32'(i);
        valid_up_in = 4'b1111;
        repeat (8) step();
        valid_up_in = 4'b0000;
        step();
        chk("rot_count", 32'(obs_ids.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_ids.size()) chk("rot_id", 32'(obs_ids[i]), 32'(i % N));
        end

        // 4: backpressure with word 0x101 held in the slot
        do_reset(2);
        ready_down_in = 1'b0;
        valid_up_in = 4'b0010;
        step();
        valid_up_in = 4'b1001;
        repeat (5) begin
            step();
            chk("bp_data", data_out, 32'h101);
            chk("bp_id", 32'(grant_id_out), 32'h1);
            chk("bp_ready", 32'(ready_up_out), 32'h0);
        end
        ready_down_in = 1'b1;
        step();
        valid_up_in = 4'b0001;
        step();
        valid_up_in = 4'b0000;
        step();
        step();
        chk("bp_count", 32'(obs_ids.size()), 32'd3);
        if (obs_ids.size() >= 3) begin
            chk("bp_order0", 32'(obs_ids[0]), 32'h1);
            chk("bp_order1", 32'(obs_ids[1]), 32'h3);
            chk("bp_order2", 32'(obs_ids[2]), 32'h0);
        end

        // 5: lane 1 toggles its request, lane 2 always requesting
        do_reset(2);
        lane[1] = 32'h1000;
        lane[2] = 32'h2000;
        valid_up_in = 4'b0110;
        l1_sent = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (last_xfer == 1) begin
                l1_sent++;
                lane[1] = lane[1] + 32'h1;
                valid_up_in[1] = 1'b0;
            end else if (!valid_up_in[1]) begin
                valid_up_in[1] = 1'b1;
            end
            if (last_xfer == 2) lane[2] = lane[2] + 32'h1;
        end
        valid_up_in = 4'b0000;
        step();
        since_l2 = 0;
        l1_seen = 0;
        foreach (obs_ids[i]) begin
            if (obs_ids[i] == 2) begin
                chk("l2_starve", 32'(since_l2 <= 1), 32'h1);
                since_l2 = 0;
            end else begin
                since_l2++;
            end
            if (obs_ids[i] == 1) l1_seen++;
        end
        chk("l1_once", 32'(l1_seen), 32'(l1_sent));
        chk("l1_some", 32'(l1_sent > 4), 32'h1);

        // 6: asynchronous reset while a word is buffered and ptr is 2
        do_reset(2);
        ready_down_in = 1'b0;
        valid_up_in = 4'b0100;
        step();
        valid_up_in = 4'b0000;
        chk("pre_rst_valid", 32'(valid_down_out), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_down_out), 32'h0);
        step();
        step();
        rst = 1'b0;
        obs_ids.delete();
        ready_down_in = 1'b1;
        valid_up_in = 4'b1001;
        step();
        valid_up_in = 4'b0000;
        step();
        chk("post_rst_first", 32'(obs_ids.size() > 0 ? obs_ids[0] : -1), 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
